// File: rtl/wb_commit_stage.sv
// Write-back commit stage: selects load data or ALU result, registers the register-file write,
// and sequences the jr redirect/flush. Optional same-cycle forwarding port under WB_FORWARD_EN.
module wb_commit_stage #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_in,
   input  logic              reg_write_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [ADDR_W-1:0] reg_address_in,
   input  logic              jump_reg_in,
   input  logic              mem_load_in,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              jr_redirect,
   output logic [DATA_W-1:0] jr_target,
   output logic              flush,
   output logic              busy,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
);

   // state    | meaning
   // IDLE     | normal commit, waiting for a jr
   // REDIRECT | one unstalled cycle: pulse jr_redirect, flush younger stages
   // FLUSH    | squash writes while the counter runs down
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_target;
   logic              w_squash;
   logic              w_busy;

   assign w_busy   = (r_state != S_IDLE);
   assign w_squash = w_busy | jump_reg_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_target <= '0;
      end else if (!stall_in) begin
         r_state <= w_next;
         r_we    <= reg_write_in & (reg_address_in != '0) & ~w_squash;
         r_waddr <= reg_address_in;
         r_wdata <= mem_load_in ? data_in : result_in;
         if ((r_state == S_IDLE) && jump_reg_in) begin
            r_target <= result_in;
            r_cnt    <= LP_FLUSH;
         end else if (r_state == S_FLUSH) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // Stall gates the held write and the redirect pulse so neither is issued twice.
   always_comb begin
      w_next      = r_state;
      jr_redirect = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!stall_in && jump_reg_in) w_next = S_REDIRECT;
         end
         S_REDIRECT: begin
            jr_redirect = ~stall_in;
            if (!stall_in) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (!stall_in && (r_cnt == 4'd1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign rf_we     = r_we & ~stall_in;
   assign rf_waddr  = r_waddr;
   assign rf_wdata  = r_wdata;
   assign jr_target = r_target;
   assign flush     = w_busy;
   assign busy      = w_busy;

`ifdef WB_FORWARD_EN
   assign fwd_valid = rf_we;
   assign fwd_addr  = r_waddr;
   assign fwd_data  = r_wdata;
`else
   assign fwd_valid = 1'b0;
   assign fwd_addr  = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: driver pushes expected commits into a queue,
// a negedge monitor pops and compares whenever rf_we is asserted.
module tb_wb_commit_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int EXP_COMMITS = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall_in = 1'b0;
   logic          reg_write_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] result_in = '0;
   logic [AW-1:0] reg_address_in = '0;
   logic          jump_reg_in = 1'b0;
   logic          mem_load_in = 1'b0;
   logic          rf_we, jr_redirect, flush, busy, fwd_valid;
   logic [AW-1:0] rf_waddr, fwd_addr;
   logic [DW-1:0] rf_wdata, jr_target, fwd_data;

   wb_commit_stage #(.DATA_W(DW), .ADDR_W(AW), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .reg_write_in(reg_write_in),
      .data_in(data_in), .result_in(result_in), .reg_address_in(reg_address_in),
      .jump_reg_in(jump_reg_in), .mem_load_in(mem_load_in),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .jr_redirect(jr_redirect), .jr_target(jr_target), .flush(flush), .busy(busy),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] exp_target = '0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            n_commit = 0;
   int            n_redir = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      reg_write_in = 1'b0; jump_reg_in = 1'b0; mem_load_in = 1'b0;
      data_in = '0; result_in = '0; reg_address_in = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic ld, input logic [DW-1:0] d,
                     input logic [DW-1:0] r);
      reg_write_in = 1'b1; reg_address_in = a; mem_load_in = ld; data_in = d; result_in = r;
   endtask

   // Monitor: every committed write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {32'd0, rf_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("commit_addr", 64'(rf_waddr), 64'(e.addr));
               chk("commit_data", 64'(rf_wdata), 64'(e.data));
               n_commit++;
            end
         end
         if (jr_redirect) begin
            n_redir++;
            chk("jr_target", 64'(jr_target), 64'(exp_target));
         end
`ifdef WB_FORWARD_EN
         chk("fwd_valid", 64'(fwd_valid), 64'(rf_we));
         if (rf_we) begin
            chk("fwd_addr", 64'(fwd_addr), 64'(rf_waddr));
            chk("fwd_data", 64'(fwd_data), 64'(rf_wdata));
         end
`else
         chk("fwd_tied", {31'd0, fwd_valid, 27'd0, fwd_addr}, 64'd0);
`endif
      end
   end

   initial begin
      int r0;
      // Reset state
      step(); step();
      chk("rst_rf_we", 64'(rf_we), 0);
      chk("rst_flush_busy", {62'd0, flush, busy}, 0);
      chk("rst_redirect", 64'(jr_redirect), 0);
      chk("rst_wdata", 64'(rf_wdata), 0);
      chk("rst_waddr", 64'(rf_waddr), 0);
      chk("rst_target", 64'(jr_target), 0);
      @(negedge clk); #2; rst_n = 1'b1;

      // ALU write, load write, zero register
      wr(5'd8, 1'b0, 32'h0, 32'h0000_1234); exp_q.push_back({5'd8, 32'h0000_1234});
      step();
      wr(5'd9, 1'b1, 32'hDEAD_BEEF, 32'h100); exp_q.push_back({5'd9, 32'hDEAD_BEEF});
      step();
      wr(5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      idle_in();
      chk("zero_reg_we", 64'(rf_we), 0);

      // Pending commit held by a stall is written exactly once after release
      wr(5'd7, 1'b0, 32'h0, 32'h77); exp_q.push_back({5'd7, 32'h77});
      step();
      idle_in(); stall_in = 1'b1;
      #0 chk("stall_hold_we", 64'(rf_we), 0);
      step(); chk("stall_hold_we", 64'(rf_we), 0);
      step(); chk("stall_hold_we", 64'(rf_we), 0);
      stall_in = 1'b0;
      #0 chk("stall_release_we", 64'(rf_we), 1);
      step();

      // jr with three following writes to r5, plus a jr arriving mid-flush
      r0 = n_redir;
      jump_reg_in = 1'b1; result_in = 32'h0040_0020; exp_target = 32'h0040_0020;
      step();
      chk("jr_redirect", 64'(jr_redirect), 1);
      chk("jr_flush", {62'd0, flush, busy}, 3);
      jump_reg_in = 1'b0; wr(5'd5, 1'b0, 32'h0, 32'hA1);
      step();
      chk("flush_c2", {62'd0, flush, jr_redirect}, 2);
      wr(5'd5, 1'b0, 32'h0, 32'hA2); jump_reg_in = 1'b1;
      step();
      chk("flush_c3", 64'(flush), 1);
      jump_reg_in = 1'b0; wr(5'd5, 1'b0, 32'h0, 32'hA3);
      step();
      chk("flush_end", {62'd0, flush, busy}, 0);
      chk("jr_target_hold", 64'(jr_target), 64'h0040_0020);
      wr(5'd5, 1'b0, 32'h0, 32'hA4); exp_q.push_back({5'd5, 32'hA4});
      step();
      idle_in();
      chk("no_restart", 64'(busy), 0);
      chk("redirect_once", 64'(n_redir - r0), 1);

      // Stall during REDIRECT and during FLUSH
      r0 = n_redir;
      jump_reg_in = 1'b1; result_in = 32'h0080_0040; exp_target = 32'h0080_0040;
      step();
      idle_in(); stall_in = 1'b1; wr(5'd6, 1'b0, 32'h0, 32'h66);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_redir_low", 64'(jr_redirect), 0);
         chk("stall_state", {62'd0, flush, busy}, 3);
         chk("stall_we", 64'(rf_we), 0);
      end
      stall_in = 1'b0; idle_in();
      #0 chk("redir_after_stall", 64'(jr_redirect), 1);
      step();
      chk("flush1", {62'd0, flush, jr_redirect}, 2);
      stall_in = 1'b1;
      step(); chk("flush_stalled", 64'(flush), 1);
      step(); chk("flush_stalled", 64'(flush), 1);
      stall_in = 1'b0;
      step(); chk("flush2", 64'(flush), 1);
      step(); chk("flush_done", {62'd0, flush, busy}, 0);
      chk("redirect_once_stall", 64'(n_redir - r0), 1);

      // Reset asserted mid-FLUSH
      jump_reg_in = 1'b1; result_in = 32'h00C0_0000; exp_target = 32'h00C0_0000;
      step();
      idle_in();
      step();
      chk("pre_reset_flush", 64'(flush), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_flush_busy", {62'd0, flush, busy}, 0);
      chk("async_rst_we", 64'(rf_we), 0);
      chk("async_rst_target", 64'(jr_target), 0);
      @(negedge clk); #2; rst_n = 1'b1;
      wr(5'd10, 1'b1, 32'hCAFE_F00D, 32'h1); exp_q.push_back({5'd10, 32'hCAFE_F00D});
      step();
      idle_in();
      step(); step();

      chk("queue_empty", 64'(exp_q.size()), 0);
      chk("commit_count", 64'(n_commit), 64'(EXP_COMMITS));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Consumer end of the MEM/WB pipeline interface; takes the MEM/WB register outputs and commits them to the register file write port.
- Selects the write-back source (memory load data or ALU result) and registers a single write-back commit.
- Drives the jr redirect to fetch and runs a flush sequencer that squashes younger writes after a jump-register.
- Sits between the MEM/WB pipeline register and the register file / fetch PC mux.

Parameters:
DATA_W, 32, width of data and ALU result paths
ADDR_W, 5, register address width
FLUSH_CYCLES, 2, cycles of squash following a jr redirect; legal 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_in  input  1  hazard stall; freezes all state while high
reg_write_in  input  1  write-enable from MEM/WB
data_in  input  DATA_W  memory load data from MEM/WB
result_in  input  DATA_W  ALU result from MEM/WB
reg_address_in  input  ADDR_W  destination register from MEM/WB
jump_reg_in  input  1  jr instruction marker from MEM/WB
mem_load_in  input  1  1 = write back data_in, 0 = write back result_in
rf_we  output  1  register file write enable
rf_waddr  output  ADDR_W  register file write address
rf_wdata  output  DATA_W  register file write data
jr_redirect  output  1  one-cycle pulse: load PC from jr_target
jr_target  output  DATA_W  jump target (captured result_in)
flush  output  1  squash younger pipeline stages
busy  output  1  FSM not in IDLE
fwd_valid  output  1  forwarding entry valid (optional feature)
fwd_addr  output  ADDR_W  forwarding register address
fwd_data  output  DATA_W  forwarding data

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. All outputs are 0 while rst_n is low. FSM enters IDLE. Flush counter is 0.
- Capture latency: 1 cycle. On a rising edge with stall_in=0, the stage registers:
  - rf_wdata = mem_load_in ? data_in : result_in
  - rf_waddr = reg_address_in
  - rf_we = reg_write_in & (reg_address_in != 0) & ~squash
- squash is 1 when the FSM is in REDIRECT or FLUSH at that edge, or when jump_reg_in is accepted at that edge. A jr itself never writes the register file.
- stall_in=1: all registers, the FSM and the counter hold their values. rf_we is forced to 0 in the stall cycle so no double write occurs. jr_redirect is held low, so the pulse is issued only once.
- FSM states:
  - IDLE: accepted jump_reg_in=1 -> REDIRECT. Register jr_target=result_in. Load counter=FLUSH_CYCLES.
  - REDIRECT: jr_redirect=1 and flush=1 for exactly one unstalled cycle, then -> FLUSH.
  - FLUSH: flush=1. The counter decrements on each unstalled edge. When the counter reaches 1 on the decrement edge -> IDLE. jump_reg_in arriving in REDIRECT or FLUSH is squashed and ignored; it does not restart the sequence.
- busy = (state != IDLE).
- jr_target holds its value until the next accepted jr.
- Boundaries:
  - FLUSH_CYCLES=1: exactly one FLUSH cycle.
  - A write to register 0 never asserts rf_we.
  - Reset asserted mid-FLUSH returns to IDLE immediately and drops flush asynchronously.
- Width rule: the data mux is pure selection; there is no extension or truncation.

Optional Feature:
- WB_FORWARD_EN defined:
  - fwd_valid, fwd_addr and fwd_data mirror rf_we, rf_waddr and rf_wdata combinationally from the commit register, so EX can bypass the value in the same cycle the register file is written.
  - fwd_valid=0 whenever rf_we=0.
- WB_FORWARD_EN undefined: fwd_valid, fwd_addr and fwd_data are tied to 0. No extra logic is synthesised.

Test Plan:
- ALU write: reg_write_in=1, addr=8, result_in=0x0000_1234, mem_load_in=0 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x0000_1234.
- Load write: mem_load_in=1, data_in=0xDEAD_BEEF, result_in=0x100, addr=9 -> rf_wdata=0xDEAD_BEEF, rf_we=1.
- Zero register: reg_write_in=1, addr=0, data=0xFFFF_FFFF -> rf_we stays 0 for the whole test.
- jr with FLUSH_CYCLES=2: jump_reg_in=1, result_in=0x0040_0020, then a write to reg 5 on each of the next 3 cycles:
  - jr_redirect pulses one cycle with jr_target=0x0040_0020.
  - flush is high for 3 cycles.
  - The reg-5 writes during flush have rf_we=0; the first write after busy falls commits.
- Stall during REDIRECT: stall_in=1 for 4 cycles -> jr_redirect is high exactly one cycle total, state and counter freeze, and rf_we=0 during the stall.
- Reset mid-FLUSH: deassert rst_n asynchronously between edges -> flush, busy and rf_we go 0 immediately. After release, a normal write commits on its first edge; with WB_FORWARD_EN, fwd_* match rf_* in every cycle.
